md5_msg_packer: RTL and testbench

MD5_MSG_PACKER -- requirements
Module: md5_msg_packer

---
 rtl/md5_pkg.sv | 16 +
 rtl/md5_pack_lane.sv | 48 ++++
 rtl/md5_msg_packer.sv | 120 ++++++++++++
 tb/tb_md5_msg_packer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/md5_pkg.sv
// Shared constants and FSM encoding for the MD5 message packer.
package md5_pkg;

    localparam int MD5_CHUNK_BYTES = 16;
    localparam int MD5_CHUNK_BITS  = 128;
    localparam int MD5_WIDTH_BITS  = 8;   // msg_in_width field size (0..128)
    localparam int MD5_COUNT_BITS  = 5;   // byte counter range 0..16

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FILL     = 2'd1,
        ST_SEND     = 2'd2,
        ST_SEND_PAD = 2'd3
    } md5_state_e;

endpackage

// File: rtl/md5_pack_lane.sv
// Byte-lane insertion and byte counter for one 128-bit chunk.
// Byte k of the chunk lands in bits [8k+7:8k]; unfilled lanes stay zero.
module md5_pack_lane
    import md5_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      accept,
    input  logic                      clear,
    input  logic [7:0]                byte_in,
    output logic [MD5_CHUNK_BITS-1:0] chunk,
    output logic [MD5_COUNT_BITS-1:0] count
);

    logic [MD5_COUNT_BITS-1:0] count_reg;
    logic [7:0]                lane_reg [MD5_CHUNK_BYTES];

    // Byte counter: advances per accepted byte, cleared when the chunk is handed off.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (accept) begin
            count_reg <= count_reg + 5'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < MD5_CHUNK_BYTES; gi++) begin : g_lane
            // Lane gi captures the byte accepted while the counter points at it.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    lane_reg[gi] <= 8'h00;
                end else if (clear) begin
                    lane_reg[gi] <= 8'h00;
                end else if (accept && (count_reg == MD5_COUNT_BITS'(gi))) begin
                    lane_reg[gi] <= byte_in;
                end
            end
            assign chunk[8*gi +: 8] = lane_reg[gi];
        end
    endgenerate

    assign count = count_reg;

endmodule

// File: rtl/md5_msg_packer.sv
// Packs a byte stream into 128-bit MD5 chunks with a valid-bit width field.
// Optional feature: define MD5_PACKER_LEN_CNT_EN to add the 64-bit msg_bit_len output.
module md5_msg_packer
    import md5_pkg::*;
#(
    parameter int CHUNK_BYTES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                byte_in,
    input  logic                      byte_valid,
    input  logic                      byte_last,
    output logic                      byte_ready,
    output logic [MD5_CHUNK_BITS-1:0] msg_in,
    output logic [MD5_WIDTH_BITS-1:0] msg_in_width,
    output logic                      msg_in_valid,
`ifdef MD5_PACKER_LEN_CNT_EN
    output logic [63:0]               msg_bit_len,
`endif
    input  logic                      core_ready
);

    md5_state_e                state_reg, state_next;
    logic                      last_reg, last_next;
    logic                      alive_reg;
    logic                      accept;
    logic                      chunk_end;
    logic                      lane_clear;
    logic [MD5_COUNT_BITS-1:0] count;
    logic [MD5_CHUNK_BITS-1:0] chunk;

    assign accept     = byte_valid && byte_ready;
    assign chunk_end  = accept && (byte_last || (count == MD5_COUNT_BITS'(CHUNK_BYTES - 1)));
    assign lane_clear = (state_reg == ST_SEND) && core_ready;

    md5_pack_lane u_lane (
        .clk     (clk),
        .reset   (reset),
        .accept  (accept),
        .clear   (lane_clear),
        .byte_in (byte_in),
        .chunk   (chunk),
        .count   (count)
    );

    // State, final-byte flag and the post-reset ready enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            last_reg  <= 1'b0;
            alive_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
            alive_reg <= 1'b1;
        end
    end

    // Next-state logic: fill until full or last byte, then offer the chunk.
    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        case (state_reg)
            ST_IDLE, ST_FILL: begin
                if (accept) begin
                    last_next  = byte_last;
                    state_next = chunk_end ? ST_SEND : ST_FILL;
                end
            end
            ST_SEND: begin
                if (core_ready) begin
                    if (!last_reg) begin
                        state_next = ST_FILL;
                    end else if (count == MD5_COUNT_BITS'(CHUNK_BYTES)) begin
                        // Exactly-full final chunk needs an empty terminator chunk.
                        state_next = ST_SEND_PAD;
                    end else begin
                        state_next = ST_IDLE;
                        last_next  = 1'b0;
                    end
                end
            end
            ST_SEND_PAD: begin
                if (core_ready) begin
                    state_next = ST_IDLE;
                    last_next  = 1'b0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                last_next  = 1'b0;
            end
        endcase
    end

    assign byte_ready   = alive_reg && ((state_reg == ST_IDLE) || (state_reg == ST_FILL));
    assign msg_in_valid = (state_reg == ST_SEND) || (state_reg == ST_SEND_PAD);
    assign msg_in       = chunk;
    assign msg_in_width = {count, 3'b000};

`ifdef MD5_PACKER_LEN_CNT_EN
    logic [63:0] bit_len_reg;

    // Total message bits; restarts on the first byte accepted in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_len_reg <= 64'd0;
        end else if (accept) begin
            if (state_reg == ST_IDLE) begin
                bit_len_reg <= 64'd8;
            end else begin
                bit_len_reg <= bit_len_reg + 64'd8;
            end
        end
    end

    assign msg_bit_len = bit_len_reg;
`endif

endmodule

// File: tb/tb_md5_msg_packer.sv
// Self-checking bench for md5_msg_packer: directed cases plus randomized messages
// checked against a chunk-list reference model.
module tb_md5_msg_packer;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_last;
    logic         byte_ready;
    logic [127:0] msg_in;
    logic [7:0]   msg_in_width;
    logic         msg_in_valid;
    logic         core_ready;
`ifdef MD5_PACKER_LEN_CNT_EN
    logic [63:0]  msg_bit_len;
`endif

    always #5 clk = ~clk;

    md5_msg_packer #(.CHUNK_BYTES(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_last    (byte_last),
        .byte_ready   (byte_ready),
        .msg_in       (msg_in),
        .msg_in_width (msg_in_width),
        .msg_in_valid (msg_in_valid),
`ifdef MD5_PACKER_LEN_CNT_EN
        .msg_bit_len  (msg_bit_len),
`endif
        .core_ready   (core_ready)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0]   msg_q [$];
    logic [127:0] exp_d [$];
    logic [7:0]   exp_w [$];
    logic [127:0] cap_d [$];
    logic [7:0]   cap_w [$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: split the message into 16-byte groups, byte k at bits 8k; pad if exact multiple.
    task automatic build_model();
        logic [127:0] acc;
        int n;
        acc = '0;
        n   = 0;
        exp_d.delete();
        exp_w.delete();
        for (int i = 0; i < msg_q.size(); i++) begin
            acc = acc | (128'(msg_q[i]) << (8 * n));
            n++;
            if (n == 16 || i == msg_q.size() - 1) begin
                exp_d.push_back(acc);
                exp_w.push_back(8'(8 * n));
                acc = '0;
                n   = 0;
            end
        end
        if (msg_q.size() % 16 == 0) begin
            exp_d.push_back('0);
            exp_w.push_back(8'd0);
        end
    endtask

    task automatic load_seq(input int n);
        msg_q.delete();
        for (int i = 0; i < n; i++) msg_q.push_back(8'(i));
    endtask

    task automatic load_hashed();
        msg_q.delete();
        msg_q.push_back(8'h48); msg_q.push_back(8'h61); msg_q.push_back(8'h73);
        msg_q.push_back(8'h68); msg_q.push_back(8'h65); msg_q.push_back(8'h64);
    endtask

    // mode 0: always ready, no gaps; 1: random gaps and backpressure; 2: hold core_ready low 10 cycles.
    task automatic run_msg(input int mode, input string name);
        int           idx;
        int           cyc;
        int           hold;
        logic         prev_valid;
        logic         prev_hs;
        logic [127:0] prev_d;
        logic [7:0]   prev_w;
        logic         exp_valid_next;
        logic         acc;
        logic         hs;
        idx = 0; cyc = 0; hold = 0;
        prev_valid = 1'b0; prev_hs = 1'b0; prev_d = '0; prev_w = '0;
        exp_valid_next = 1'b0;
        build_model();
        cap_d.delete();
        cap_w.delete();
        forever begin
            @(negedge clk);
            if (exp_valid_next) chk({name, " latency"}, 128'(msg_in_valid), 128'(1));
            exp_valid_next = 1'b0;
            if (prev_valid && !prev_hs) begin
                chk({name, " hold_valid"}, 128'(msg_in_valid), 128'(1));
                chk({name, " hold_data"}, msg_in, prev_d);
                chk({name, " hold_width"}, 128'(msg_in_width), 128'(prev_w));
            end
            if (msg_in_valid) chk({name, " ready_low_in_send"}, 128'(byte_ready), 128'(0));
            if (idx >= msg_q.size() && exp_d.size() == 0) break;
            if (cyc >= 3000) begin
                chk({name, " pending_at_timeout"}, 128'(exp_d.size() + msg_q.size() - idx), 128'(0));
                break;
            end
            cyc++;
            case (mode)
                1:       core_ready = ($urandom_range(0, 9) < 7);
                2: begin
                    if (msg_in_valid && hold < 10) begin
                        core_ready = 1'b0;
                        hold++;
                    end else begin
                        core_ready = 1'b1;
                    end
                end
                default: core_ready = 1'b1;
            endcase
            if (idx < msg_q.size()) begin
                byte_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
                byte_in    = msg_q[idx];
                byte_last  = (idx == msg_q.size() - 1);
            end else begin
                byte_valid = 1'b0;
                byte_in    = 8'($urandom);
                byte_last  = 1'($urandom);
            end
            acc = byte_valid && byte_ready;
            hs  = msg_in_valid && core_ready;
            if (hs) begin
                if (exp_d.size() == 0) begin
                    chk({name, " spurious_chunk"}, 128'(msg_in_valid), 128'(0));
                end else begin
                    chk({name, " chunk_data"}, msg_in, exp_d[0]);
                    chk({name, " chunk_width"}, 128'(msg_in_width), 128'(exp_w[0]));
                    void'(exp_d.pop_front());
                    void'(exp_w.pop_front());
                end
                cap_d.push_back(msg_in);
                cap_w.push_back(msg_in_width);
            end
            if (acc) begin
                if (idx == msg_q.size() - 1 || idx % 16 == 15) exp_valid_next = 1'b1;
                idx++;
            end
            prev_valid = msg_in_valid;
            prev_hs    = hs;
            prev_d     = msg_in;
            prev_w     = msg_in_width;
        end
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        core_ready = 1'b1;
        chk({name, " idle_valid"}, 128'(msg_in_valid), 128'(0));
        chk({name, " idle_ready"}, 128'(byte_ready), 128'(1));
`ifdef MD5_PACKER_LEN_CNT_EN
        chk({name, " bit_len"}, 128'(msg_bit_len), 128'(8 * msg_q.size()));
`endif
        $display("msg %s len=%0d chunks=%0d cycles=%0d", name, msg_q.size(), cap_d.size(), cyc);
    endtask

    initial begin
        reset      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        byte_last  = 1'b0;
        core_ready = 1'b1;
        #1;
        chk("reset byte_ready", 128'(byte_ready), 128'(0));
        chk("reset msg_in", msg_in, 128'(0));
        chk("reset width", 128'(msg_in_width), 128'(0));
        chk("reset valid", 128'(msg_in_valid), 128'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_reset ready", 128'(byte_ready), 128'(1));

        load_hashed();
        run_msg(0, "hashed");
        chk("hashed n_chunks", 128'(cap_d.size()), 128'(1));
        chk("hashed data", cap_d[0], 128'h646568736148);
        chk("hashed width", 128'(cap_w[0]), 128'(48));

        load_seq(16);
        run_msg(0, "seq16");
        chk("seq16 n_chunks", 128'(cap_d.size()), 128'(2));
        chk("seq16 data", cap_d[0], 128'h0F0E0D0C0B0A09080706050403020100);
        chk("seq16 width", 128'(cap_w[0]), 128'(128));
        chk("seq16 pad_data", cap_d[1], 128'(0));
        chk("seq16 pad_width", 128'(cap_w[1]), 128'(0));

        load_seq(20);
        run_msg(0, "seq20");
        chk("seq20 n_chunks", 128'(cap_d.size()), 128'(2));
        chk("seq20 width0", 128'(cap_w[0]), 128'(128));
        chk("seq20 data1", cap_d[1], 128'h13121110);
        chk("seq20 width1", 128'(cap_w[1]), 128'(32));
`ifdef MD5_PACKER_LEN_CNT_EN
        chk("seq20 bit_len", 128'(msg_bit_len), 128'(160));
`endif

        load_seq(20);
        run_msg(2, "seq20_hold");

        // Abort a message after 5 bytes with an asynchronous reset.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            byte_valid = 1'b1;
            byte_in    = 8'(8'hA0 + i);
            byte_last  = 1'b0;
        end
        @(negedge clk);
        byte_valid = 1'b0;
        chk("mid_msg partial", 128'(msg_in_width), 128'(40));
        reset = 1'b0;
        #1;
        chk("mid_reset ready", 128'(byte_ready), 128'(0));
        chk("mid_reset msg_in", msg_in, 128'(0));
        chk("mid_reset width", 128'(msg_in_width), 128'(0));
        chk("mid_reset valid", 128'(msg_in_valid), 128'(0));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_reset ready_after", 128'(byte_ready), 128'(1));
        load_hashed();
        run_msg(0, "hashed_after_reset");
        chk("hashed2 n_chunks", 128'(cap_d.size()), 128'(1));
        chk("hashed2 data", cap_d[0], 128'h646568736148);
        chk("hashed2 width", 128'(cap_w[0]), 128'(48));

        for (int m = 0; m < 25; m++) begin
            int len;
            len = $urandom_range(1, 40);
            if (m < 3) len = 16 * (m + 1);
            msg_q.delete();
            for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
            run_msg(1, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
